uart_tx_gen: RTL
================

UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal 5..9.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, input buffer words, power of two, at least 2.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 1, CLK cycles per serial bit, at least 1.
REQ-004 The block SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port P_DATA  input  DATA_WIDTH  parallel word to send.
REQ-007 The block SHALL have port Data_Valid  input  1  write strobe for P_DATA.
REQ-008 The block SHALL have port DATA_READY  output  1  high when the FIFO is not full.
REQ-009 The block SHALL have port PAR_EN  input  1  parity bit enable.
REQ-010 The block SHALL have port PAR_TYP  input  1  parity type: 0 even, 1 odd.
REQ-011 The block SHALL have port STOP2  input  1  stop bits: 0 one, 1 two.
REQ-012 The block SHALL have port TX_OUT  output  1  registered serial line, idle high.
REQ-013 The block SHALL have port busy  output  1  high while a frame is in progress.
REQ-014 The block SHALL have port FIFO_COUNT  output  clog2(FIFO_DEPTH)+1  words buffered.

Function
REQ-015 The FIFO SHALL accept a write on a rising edge where Data_Valid=1 and DATA_READY=1; a word presented with DATA_READY=0 SHALL be dropped with no state change.
REQ-016 DATA_READY SHALL equal (FIFO_COUNT != FIFO_DEPTH), decoded from registered state only.
REQ-017 A write and a pop in the same cycle SHALL leave FIFO_COUNT unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with FIFO_COUNT>0, the FSM SHALL pop one word, latch PAR_EN, PAR_TYP, and STOP2, and enter START on the next edge.
REQ-020 A word written at edge n into an empty FIFO while IDLE SHALL drive TX_OUT=0 (start bit) from edge n+2.
REQ-021 Each bit SHALL be held on TX_OUT for exactly CLKS_PER_BIT cycles, timed by an internal counter that reloads at every bit boundary.
REQ-022 START SHALL output 0; DATA SHALL output DATA_WIDTH bits LSB first.
REQ-023 After DATA, the FSM SHALL go to PARITY if latched PAR_EN=1, else to STOP.
REQ-024 The parity bit SHALL be the XOR of all data bits for even parity, and its inverse for odd parity, computed from the latched word.
REQ-025 STOP SHALL output 1 for one bit time, or for two bit times if latched STOP2=1.
REQ-026 At the end of the final stop bit, the FSM SHALL go directly to START, popping and re-latching configuration, if FIFO_COUNT>0; otherwise it SHALL go to IDLE, with no idle gap between back-to-back frames.
REQ-027 busy SHALL be 1 in every state except IDLE, registered with the state.
REQ-028 Changes to PAR_EN, PAR_TYP, or STOP2 mid-frame SHALL NOT affect the current frame.
REQ-029 Frame length SHALL be (1+DATA_WIDTH+PAR_EN+1+STOP2)*CLKS_PER_BIT cycles.

Reset
REQ-030 RST=0 SHALL immediately force TX_OUT=1, busy=0, state IDLE, FIFO_COUNT=0, DATA_READY=1, pointers 0, and bit counter 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame and flush the FIFO; no partial frame SHALL resume after release.
REQ-032 A write at the first edge after reset release SHALL be accepted.

Verification
REQ-033 Defaults, PAR_EN=1, PAR_TYP=0, STOP2=0, write 0xA5 -> TX_OUT from edge n+2 = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles), busy high for those 11 cycles, then IDLE.
REQ-034 PAR_TYP=1, write 0x01 -> parity bit 0; PAR_TYP=0, write 0x01 -> parity bit 1; PAR_EN=0 -> 10-cycle frame with no parity bit.
REQ-035 CLKS_PER_BIT=4, STOP2=1, PAR_EN=0, write 0x3C -> each bit held 4 cycles; 44-cycle frame; last 8 cycles high.
REQ-036 FIFO_DEPTH=4, 8 back-to-back writes 0x10..0x17 while the first frame runs -> DATA_READY drops at FIFO_COUNT=4, excess words dropped, accepted words sent in order with stop bit directly followed by start bit.
REQ-037 RST pulsed low during data bit 3 -> TX_OUT=1, busy=0, FIFO_COUNT=0 in the same cycle; line stays high after release until a new write.

Source files
------------

// File: rtl/uart_tx_gen.sv
// UART transmitter: parallel words are buffered in a small FIFO and sent as start/data/parity/stop frames.
// Latency: a word written at edge n into an empty, idle block puts its start bit on TX_OUT from edge n+2.
// Backpressure: DATA_READY is low while the FIFO is full; a word offered then is dropped.
//
// Ports:
//   CLK, RST        single rising-edge clock, asynchronous active-low reset
//   P_DATA          parallel word to send (DATA_WIDTH bits)
//   Data_Valid      write strobe for P_DATA, accepted when DATA_READY=1
//   DATA_READY      FIFO not full
//   PAR_EN/PAR_TYP  parity enable, parity type (0 even, 1 odd); sampled when a word is popped
//   STOP2           two stop bits when 1; sampled when a word is popped
//   TX_OUT          registered serial line, idle high
//   busy            frame in progress, aligned with the bits on TX_OUT
//   FIFO_COUNT      number of words buffered
module uart_tx_gen #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          Data_Valid,
  output logic                          DATA_READY,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  output logic                          TX_OUT,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW  = $clog2(DATA_WIDTH);

  localparam logic [BCW-1:0] BIT_RELOAD = BCW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]  FULL_CNT   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_en;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  assign DATA_READY = (count != FULL_CNT);
  assign FIFO_COUNT = count;
  assign wr_en      = Data_Valid && DATA_READY;
  assign head       = mem[rd_ptr];

  // Storage needs no reset: validity is carried entirely by count and pointers.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= P_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t                state;
  state_t                state_next;
  logic [BCW-1:0]        bit_cnt;
  logic                  bit_end;
  logic                  load_bit;
  logic                  shift;
  logic                  stop_next;
  logic                  tx_bit;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         data_idx;
  logic                  par_bit;
  logic                  par_en_q;
  logic                  stop2_q;
  logic                  second_stop;

  assign bit_end = (bit_cnt == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_bit   = 1'b0;
    shift      = 1'b0;
    stop_next  = 1'b0;
    tx_bit     = 1'b1;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          load_bit   = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (bit_end) begin
          load_bit   = 1'b1;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        tx_bit = shreg[0];
        if (bit_end) begin
          load_bit = 1'b1;
          if (data_idx == LAST_IDX) begin
            state_next = par_en_q ? S_PARITY : S_STOP;
          end else begin
            shift = 1'b1;
          end
        end
      end
      S_PARITY: begin
        tx_bit = par_bit;
        if (bit_end) begin
          load_bit   = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        tx_bit = 1'b1;
        if (bit_end) begin
          if (stop2_q && !second_stop) begin
            load_bit  = 1'b1;
            stop_next = 1'b1;
          end else if (count != '0) begin
            // Chain straight into the next frame: no idle bit between frames.
            pop        = 1'b1;
            load_bit   = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Frame datapath. Config is captured with the word so mid-frame input
  // changes only affect the next frame. TX_OUT and busy are registered from
  // the current state, so they trail the state register by one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      data_idx    <= '0;
      par_bit     <= 1'b0;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      second_stop <= 1'b0;
      TX_OUT      <= 1'b1;
      busy        <= 1'b0;
    end else begin
      if (load_bit) begin
        bit_cnt <= BIT_RELOAD;
      end else if (bit_cnt != '0) begin
        bit_cnt <= bit_cnt - BCW'(1);
      end

      if (pop) begin
        shreg       <= head;
        data_idx    <= '0;
        par_bit     <= (^head) ^ PAR_TYP;
        par_en_q    <= PAR_EN;
        stop2_q     <= STOP2;
        second_stop <= 1'b0;
      end else begin
        if (shift) begin
          shreg    <= shreg >> 1;
          data_idx <= data_idx + IW'(1);
        end
        if (stop_next) begin
          second_stop <= 1'b1;
        end
      end

      TX_OUT <= tx_bit;
      busy   <= (state != S_IDLE);
    end
  end

endmodule
